// File: rtl/pwm_bank_pkg.sv
// ============================================================================
//  Module      : pwm_bank_pkg
//  Description : Register map, CTRL bit positions and bus decode helpers for
//                the pwm_bank peripheral.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pwm_bank_pkg;

    localparam logic [5:0] OFF_CTRL    = 6'h00;
    localparam logic [5:0] OFF_PERIOD  = 6'h04;
    localparam logic [5:0] OFF_STATUS  = 6'h08;
    localparam logic [5:0] OFF_DUTY0   = 6'h10;
    localparam int         DUTY_STRIDE = 4;
    localparam int         MAX_CH      = 12;

    localparam int CTRL_GEN_BIT    = 0;
    localparam int CTRL_CHEN_LSB   = 1;
    localparam int CTRL_CENTER_BIT = 31;

    typedef enum logic [2:0] {
        REG_NONE   = 3'd0,
        REG_CTRL   = 3'd1,
        REG_PERIOD = 3'd2,
        REG_STATUS = 3'd3,
        REG_DUTY   = 3'd4
    } reg_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    // Byte offsets are word aligned by masking, so bits[1:0] never matter.
    function automatic reg_e decode_reg(input logic [5:0] a);
        logic [5:0] w;
        w = a & 6'h3C;
        if (w == OFF_CTRL)        return REG_CTRL;
        else if (w == OFF_PERIOD) return REG_PERIOD;
        else if (w == OFF_STATUS) return REG_STATUS;
        else if (w >= OFF_DUTY0 && 4'((w - OFF_DUTY0) / DUTY_STRIDE) < 4'(MAX_CH))
            return REG_DUTY;
        else                      return REG_NONE;
    endfunction

    function automatic logic [3:0] duty_index(input logic [5:0] a);
        return 4'(((a & 6'h3C) - OFF_DUTY0) / DUTY_STRIDE);
    endfunction

endpackage

`default_nettype wire

// File: rtl/pwm_bank_ch.sv
// ============================================================================
//  Module      : pwm_bank_ch
//  Description : One PWM channel - shadow/active duty pair, compare against the
//                shared counter and a registered output.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm_bank_ch #(
    parameter int CW = 11
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_i,
    input  logic [CW-1:0] wdata_i,
    input  logic          load_i,
    input  logic          en_i,
    input  logic [CW-1:0] cnt_i,
    output logic [CW-1:0] duty_o,
    output logic          pwm_o
);

    logic [CW-1:0] duty_sh_q;
    logic [CW-1:0] duty_act_q;
    logic          pwm_q;

    // Active copy takes the pre-write shadow when a write lands on a load edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            duty_sh_q  <= '0;
            duty_act_q <= '0;
            pwm_q      <= 1'b0;
        end else begin
            if (wr_i)
                duty_sh_q <= wdata_i;
            if (load_i)
                duty_act_q <= duty_sh_q;
            pwm_q <= en_i & (cnt_i < duty_act_q);
        end
    end

    assign duty_o = duty_sh_q;
    assign pwm_o  = pwm_q;

endmodule

`default_nettype wire

// File: rtl/pwm_bank.sv
// ============================================================================
//  Module      : pwm_bank
//  Description : Memory-mapped multi-channel PWM with shared period counter and
//                shadowed PERIOD/DUTY registers applied at period wrap.
//                Optional centre-aligned mode under `PWM_CENTER_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm_bank
    import pwm_bank_pkg::*;
#(
    parameter int NCH = 4,
    parameter int CW  = 11
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           sel,
    input  logic           we,
    input  logic [5:0]     addr,
    input  logic [31:0]    wdata,
    output logic [31:0]    rdata,
    output logic [NCH-1:0] pwm_out,
    output logic           period_irq
);

    reg_e          w_reg;
    logic [3:0]    w_didx;
    logic          w_wr;
    logic          w_wr_ctrl;
    logic          w_wr_per;
    logic          w_wr_stat;
    logic          w_wrap;
    logic          w_load;
    logic          w_unused;

    logic          gen_q;
    logic [NCH-1:0] chen_q;
    logic [CW-1:0] per_sh_q;
    logic [CW-1:0] per_act_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          wrap_st_q;
    logic          irq_q;

    logic [CW-1:0] w_duty_sh [NCH];

`ifdef PWM_CENTER_EN
    logic          center_q;
    logic          center_d;
    logic          center_act_q;
    dir_e          dir_q;
    dir_e          dir_d;
`endif

    assign w_reg     = decode_reg(addr);
    assign w_didx    = duty_index(addr);
    assign w_wr      = sel & we;
    assign w_wr_ctrl = w_wr && (w_reg == REG_CTRL);
    assign w_wr_per  = w_wr && (w_reg == REG_PERIOD);
    assign w_wr_stat = w_wr && (w_reg == REG_STATUS);
    assign w_load    = ~gen_q | w_wrap;
    assign w_unused  = ^{addr[1:0], wdata};

    // Shared counter: edge-aligned wraps at per_act; centre-aligned wraps at 0 on the way down.
    always_comb begin
        cnt_d  = cnt_q;
        w_wrap = 1'b0;
`ifdef PWM_CENTER_EN
        dir_d    = dir_q;
        center_d = w_wr_ctrl ? wdata[CTRL_CENTER_BIT] : center_q;
`endif
        if (!gen_q) begin
            cnt_d = '0;
`ifdef PWM_CENTER_EN
            dir_d = DIR_UP;
`endif
        end else begin
`ifdef PWM_CENTER_EN
            if (center_act_q) begin
                if (per_act_q == '0) begin
                    w_wrap = 1'b1;
                    cnt_d  = '0;
                    dir_d  = DIR_UP;
                end else if (dir_q == DIR_UP) begin
                    if (cnt_q == per_act_q) begin
                        cnt_d = cnt_q - CW'(1);
                        dir_d = DIR_DOWN;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else if (cnt_q == '0) begin
                    // Count 0 belongs to the ending period; the new one resumes at 1.
                    w_wrap = 1'b1;
                    dir_d  = DIR_UP;
                    cnt_d  = (per_sh_q == '0) ? '0 : CW'(1);
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end else
`endif
            if (cnt_q == per_act_q) begin
                w_wrap = 1'b1;
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            gen_q     <= 1'b0;
            chen_q    <= '0;
            per_sh_q  <= '0;
            per_act_q <= '0;
            cnt_q     <= '0;
            wrap_st_q <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            irq_q <= w_wrap;
            if (w_wr_ctrl) begin
                gen_q  <= wdata[CTRL_GEN_BIT];
                chen_q <= wdata[CTRL_CHEN_LSB +: NCH];
            end
            if (w_wr_per)
                per_sh_q <= wdata[CW-1:0];
            if (w_load)
                per_act_q <= per_sh_q;
            if (w_wrap)
                wrap_st_q <= 1'b1;
            else if (w_wr_stat && wdata[0])
                wrap_st_q <= 1'b0;
        end
    end

`ifdef PWM_CENTER_EN
    // While idle the mode follows the incoming CTRL write so GEN and CENTER can rise together.
    always_ff @(posedge clk) begin
        if (reset) begin
            center_q     <= 1'b0;
            center_act_q <= 1'b0;
            dir_q        <= DIR_UP;
        end else begin
            center_q <= center_d;
            dir_q    <= dir_d;
            if (!gen_q)
                center_act_q <= center_d;
            else if (w_wrap)
                center_act_q <= center_q;
        end
    end
`endif

    generate
        for (genvar i = 0; i < NCH; i++) begin : g_ch
            logic w_wr_duty;
            assign w_wr_duty = w_wr && (w_reg == REG_DUTY) && (w_didx == 4'(i));

            pwm_bank_ch #(
                .CW (CW)
            ) u_ch (
                .clk     (clk),
                .reset   (reset),
                .wr_i    (w_wr_duty),
                .wdata_i (wdata[CW-1:0]),
                .load_i  (w_load),
                .en_i    (gen_q & chen_q[i]),
                .cnt_i   (cnt_q),
                .duty_o  (w_duty_sh[i]),
                .pwm_o   (pwm_out[i])
            );
        end
    endgenerate

    always_comb begin
        rdata = '0;
        if (sel) begin
            case (w_reg)
                REG_CTRL: begin
                    rdata[CTRL_GEN_BIT]           = gen_q;
                    rdata[CTRL_CHEN_LSB +: NCH]   = chen_q;
`ifdef PWM_CENTER_EN
                    rdata[CTRL_CENTER_BIT]        = center_q;
`endif
                end
                REG_PERIOD: rdata[CW-1:0] = per_sh_q;
                REG_STATUS: rdata[0]      = wrap_st_q;
                REG_DUTY: begin
                    for (int i = 0; i < NCH; i++) begin
                        if (w_didx == 4'(i))
                            rdata[CW-1:0] = w_duty_sh[i];
                    end
                end
                default: rdata = '0;
            endcase
        end
    end

    assign period_irq = irq_q;

endmodule

`default_nettype wire

// File: tb/tb_pwm_bank.sv
// ============================================================================
//  Module      : tb_pwm_bank
//  Description : Directed self-checking bench for pwm_bank (NCH=4, CW=11).
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_pwm_bank;

    localparam int NCH = 4;
    localparam int CW  = 11;

    localparam logic [5:0] A_CTRL   = 6'h00;
    localparam logic [5:0] A_PERIOD = 6'h04;
    localparam logic [5:0] A_STATUS = 6'h08;
    localparam logic [5:0] A_DUTY0  = 6'h10;
    localparam logic [5:0] A_DUTY1  = 6'h14;

    logic           clk = 1'b0;
    logic           reset;
    logic           sel;
    logic           we;
    logic [5:0]     addr;
    logic [31:0]    wdata;
    logic [31:0]    rdata;
    logic [NCH-1:0] pwm_out;
    logic           period_irq;

    int n_chk  = 0;
    int n_fail = 0;
    int hi0, hi1, irqs;
    logic [31:0] rv;

    always #5 clk = ~clk;

    pwm_bank #(
        .NCH (NCH),
        .CW  (CW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .sel        (sel),
        .we         (we),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .pwm_out    (pwm_out),
        .period_irq (period_irq)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (pwm_out[0]) hi0++;
        if (pwm_out[1]) hi1++;
        if (period_irq) irqs++;
    endtask

    task automatic clr();
        hi0 = 0; hi1 = 0; irqs = 0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wr(input logic [5:0] a, input logic [31:0] d);
        sel = 1'b1; we = 1'b1; addr = a; wdata = d;
        tick();
        sel = 1'b0; we = 1'b0;
    endtask

    task automatic rd(input logic [5:0] a, output logic [31:0] d);
        sel = 1'b1; we = 1'b0; addr = a;
        #1;
        d = rdata;
        sel = 1'b0;
    endtask

    task automatic wait_irq(input string tag);
        int k;
        k = 0;
        while (!period_irq && k < 40) begin
            tick();
            k++;
        end
        check(tag, {31'b0, period_irq}, 32'd1);
    endtask

    initial begin
        clr();
        // Reset with a live CTRL write on the bus: the write must not land.
        reset = 1'b1; sel = 1'b1; we = 1'b1; addr = A_CTRL; wdata = 32'h1;
        tick();
        tick();
        reset = 1'b0; sel = 1'b0; we = 1'b0;
        check("rst_pwm", {28'b0, pwm_out}, 32'h0);
        check("rst_irq", {31'b0, period_irq}, 32'h0);
        rd(A_CTRL, rv);   check("rst_ctrl", rv, 32'h0);
        rd(A_PERIOD, rv); check("rst_period", rv, 32'h0);
        rd(A_STATUS, rv); check("rst_status", rv, 32'h0);
        run(3);
        check("rst_idle_pwm", {28'b0, pwm_out}, 32'h0);

        // Edge-aligned: period 10, duty 3.
        wr(A_PERIOD, 32'd9);
        wr(A_DUTY0, 32'd3);
        wr(A_CTRL, 32'h3);
        clr(); run(10);
        check("p1_high", hi0, 3);
        check("p1_irqs", irqs, 1);
        check("p1_irq_at_wrap", {31'b0, period_irq}, 32'd1);
        clr(); run(10);
        check("p2_high", hi0, 3);
        check("p2_irqs", irqs, 1);
        rd(A_PERIOD, rv); check("period_rb", rv, 32'd9);

        // Duty change mid-period applies only after the next wrap.
        clr(); run(4);
        wr(A_DUTY0, 32'd7);
        rd(A_DUTY0, rv); check("duty0_shadow_rb", rv, 32'd7);
        run(5);
        check("p3_high_old_duty", hi0, 3);
        check("p3_irq_at_wrap", {31'b0, period_irq}, 32'd1);
        clr(); run(10);
        check("p4_high_new_duty", hi0, 7);

        // Channel 1: duty 0 low, duty > period high, CHEN drop next edge.
        wr(A_DUTY1, 32'd0);
        wr(A_CTRL, 32'h7);
        clr(); run(10);
        check("ch1_duty0_high", hi1, 0);
        wr(A_DUTY1, 32'd10);
        wait_irq("ch1_wait_wrap");
        clr(); run(10);
        check("ch1_full_high", hi1, 10);
        wr(A_CTRL, 32'h3);
        check("ch1_lag", {31'b0, pwm_out[1]}, 32'd1);
        tick();
        check("ch1_chen_off", {31'b0, pwm_out[1]}, 32'd0);

        // STATUS W1C: set wins on the wrap edge, clears off-wrap.
        rd(A_STATUS, rv); check("status_set", rv, 32'd1);
        wait_irq("st_wait_wrap");
        run(9);
        wr(A_STATUS, 32'd1);
        check("st_w1c_wrap_irq", {31'b0, period_irq}, 32'd1);
        rd(A_STATUS, rv); check("st_w1c_on_wrap", rv, 32'd1);
        wr(A_STATUS, 32'd1);
        rd(A_STATUS, rv); check("st_w1c_off_wrap", rv, 32'd0);

        // Unmapped space and deselected reads.
        wr(6'h0C, 32'hFFFF);
        rd(6'h0C, rv); check("unmapped_rd", rv, 32'd0);
        rd(6'h20, rv); check("duty4_unmapped_rd", rv, 32'd0);
        sel = 1'b0; addr = A_PERIOD; #1;
        check("nosel_rd", rdata, 32'd0);

        // GEN off aborts the period: no output, no irq.
        wr(A_CTRL, 32'h0);
        tick();
        clr(); run(12);
        check("gen_off_high", hi0, 0);
        check("gen_off_irqs", irqs, 0);

        // Zero period: wrap every cycle, output high while duty > 0.
        wr(A_PERIOD, 32'd0);
        wr(A_DUTY0, 32'd1);
        wr(A_CTRL, 32'h3);
        tick();
        clr(); run(5);
        check("per0_high", hi0, 5);
        check("per0_irqs", irqs, 5);

        wr(A_CTRL, 32'hFFFF_FFFF);
        rd(A_CTRL, rv);
`ifdef PWM_CENTER_EN
        check("ctrl_rb_all", rv, 32'h8000_001F);
`else
        check("ctrl_rb_all", rv, 32'h0000_001F);
`endif
        wr(A_CTRL, 32'h0);

`ifdef PWM_CENTER_EN
        // Centre-aligned: cnt 1,2,3,4,3,2,1,0 per period; duty 2 gives 3 centred highs.
        reset = 1'b1; tick(); reset = 1'b0;
        wr(A_PERIOD, 32'd4);
        wr(A_DUTY0, 32'd2);
        wr(A_CTRL, 32'h8000_0003);
        wait_irq("ctr_wait_wrap");
        clr(); run(8);
        check("ctr_high", hi0, 3);
        check("ctr_irqs", irqs, 1);
        check("ctr_irq_at_wrap", {31'b0, period_irq}, 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
